// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: one-entry valid/ready register, load extraction and writeback mux.
// Optional 64-bit retire counter and retire_count port are enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [XLEN-1:0] mem_rdata_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic [1:0]      addr_lo_in,
  input  logic [2:0]      funct3_in,
  input  logic [1:0]      wb_sel_in,
  input  logic [RA_W-1:0] rd_in,
  input  logic            reg_write_in,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [RA_W-1:0] rd_out,
  output logic            reg_write_out,
  output logic [XLEN-1:0] wb_data
`ifdef MEM_WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic            reg_write_q, reg_write_d;

  logic capture;
  logic retire;

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign retire   = valid_q && out_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d      = valid_q;
    mem_rdata_d  = mem_rdata_q;
    alu_result_d = alu_result_q;
    pc_plus4_d   = pc_plus4_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    wb_sel_d     = wb_sel_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    if (capture) begin
      valid_d      = 1'b1;
      mem_rdata_d  = mem_rdata_in;
      alu_result_d = alu_result_in;
      pc_plus4_d   = pc_plus4_in;
      addr_lo_d    = addr_lo_in;
      funct3_d     = funct3_in;
      wb_sel_d     = wb_sel_in;
      rd_d         = rd_in;
      reg_write_d  = reg_write_in;
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      mem_rdata_q  <= '0;
      alu_result_q <= '0;
      pc_plus4_q   <= '0;
      addr_lo_q    <= '0;
      funct3_q     <= '0;
      wb_sel_q     <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      mem_rdata_q  <= mem_rdata_d;
      alu_result_q <= alu_result_d;
      pc_plus4_q   <= pc_plus4_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      wb_sel_q     <= wb_sel_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
    end
  end

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;

  // Halfword selection looks only at addr_lo_q[1]; misaligned bit 0 is ignored.
  always_comb begin
    load_byte = mem_rdata_q[7:0];
    case (addr_lo_q)
      2'd1:    load_byte = mem_rdata_q[15:8];
      2'd2:    load_byte = mem_rdata_q[23:16];
      2'd3:    load_byte = mem_rdata_q[31:24];
      default: load_byte = mem_rdata_q[7:0];
    endcase
    load_half = addr_lo_q[1] ? mem_rdata_q[31:16] : mem_rdata_q[15:0];

    load_data = mem_rdata_q;
    case (funct3_q)
      F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = mem_rdata_q;
    endcase
  end

  always_comb begin
    case (wb_sel_q)
      WB_MEM:  wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4_q;
      default: wb_data = alu_result_q;
    endcase
  end

  assign out_valid     = valid_q;
  assign rd_out        = rd_q;
  assign reg_write_out = valid_q && reg_write_q && (rd_q != '0);

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Counts every completed output handshake, including one in a flush cycle; wraps naturally.
  always_comb begin
    retire_cnt_d = retire_cnt_q + 64'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) retire_cnt_q <= '0;
    else       retire_cnt_q <= retire_cnt_d;
  end

  assign retire_count = retire_cnt_q;
`endif

endmodule
